// File: rtl/serial_cmd_initiator_if.sv
// Signal bundle between a local controller, the command initiator and its UART pair.
// The slave modport is the initiator's own view; the master modport is everything around it.
interface serial_cmd_initiator_if #(
   parameter int MAXRESP = 32
) ();
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [7:0]             cmd_opcode;
   logic [2:0]             cmd_nargs;
   logic [31:0]            cmd_args;
   logic [5:0]             cmd_nresp;
   logic                   txBusy;
   logic                   txStart;
   logic [7:0]             txData;
   logic                   rxReady;
   logic [7:0]             rxData;
   logic                   resp_valid;
   logic                   resp_timeout;
   logic [5:0]             resp_count;
   logic [8*MAXRESP-1:0]   resp_data;
   logic                   busy;

   modport slave (
      input  cmd_valid, cmd_opcode, cmd_nargs, cmd_args, cmd_nresp,
      input  txBusy, rxReady, rxData,
      output cmd_ready, txStart, txData,
      output resp_valid, resp_timeout, resp_count, resp_data, busy
   );

   modport master (
      output cmd_valid, cmd_opcode, cmd_nargs, cmd_args, cmd_nresp,
      output txBusy, rxReady, rxData,
      input  cmd_ready, txStart, txData,
      input  resp_valid, resp_timeout, resp_count, resp_data, busy
   );
endinterface

// File: rtl/serial_cmd_initiator.sv
// Initiator side of the byte-serial command protocol: sends opcode plus 0-4 argument
// bytes to a UART transmitter, then gathers up to MAXRESP reply bytes with an idle timeout.
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready high
// TX_WAIT | current byte on txData, waiting for txBusy low to pulse txStart
// TX_GAP  | one idle cycle after txStart so the UART can raise txBusy
// RX      | collecting reply bytes, inactivity timer running
// DONE    | one-cycle resp_valid pulse
module serial_cmd_initiator #(
   parameter int MAXRESP = 32,
   parameter int TIMEOUT = 1000000
) (
   input  logic                  clk,
   input  logic                  reset,
   serial_cmd_initiator_if.slave bus
);
   localparam int             TW       = $clog2(TIMEOUT);
   localparam logic [TW-1:0]  TMO_LOAD = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, TX_WAIT, TX_GAP, RX, DONE} state_t;

   state_t               state;
   state_t               state_nx;
   logic                 tx_start;
   logic [31:0]          args_q;
   logic [2:0]           nargs_q;
   logic [2:0]           idx;
   logic [5:0]           nresp_q;
   logic [TW-1:0]        tmo_cnt;
   logic [7:0]           tx_data;
   logic [5:0]           resp_count;
   logic [8*MAXRESP-1:0] resp_data;
   logic                 resp_timeout;
   logic [2:0]           nargs_cl;
   logic [5:0]           nresp_cl;
   logic [7:0]           arg_byte;
   logic                 rx_last;
   logic                 tmo_hit;

   assign nargs_cl = (bus.cmd_nargs > 3'd4) ? 3'd4 : bus.cmd_nargs;
   assign nresp_cl = (bus.cmd_nresp > 6'(MAXRESP)) ? 6'(MAXRESP) : bus.cmd_nresp;
   assign rx_last  = (resp_count + 6'd1) == nresp_q;
   assign tmo_hit  = (tmo_cnt == '0);

   // idx is the index of the byte just sent; the next argument is byte idx of args
   always_comb begin
      arg_byte = 8'h00;
      case (idx[1:0])
         2'd0: arg_byte = args_q[7:0];
         2'd1: arg_byte = args_q[15:8];
         2'd2: arg_byte = args_q[23:16];
         2'd3: arg_byte = args_q[31:24];
         default: arg_byte = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      tx_start = 1'b0;
      case (state)
         IDLE: begin
            if (bus.cmd_valid) state_nx = TX_WAIT;
         end
         TX_WAIT: begin
            if (!bus.txBusy) begin
               tx_start = 1'b1;
               state_nx = TX_GAP;
            end
         end
         TX_GAP: begin
            if (idx < nargs_q)       state_nx = TX_WAIT;
            else if (nresp_q == '0)  state_nx = DONE;
            else                     state_nx = RX;
         end
         RX: begin
            if (bus.rxReady) begin
               if (rx_last) state_nx = DONE;
            end else if (tmo_hit) begin
               state_nx = DONE;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         args_q       <= '0;
         nargs_q      <= '0;
         idx          <= '0;
         nresp_q      <= '0;
         tmo_cnt      <= '0;
         tx_data      <= '0;
         resp_count   <= '0;
         resp_data    <= '0;
         resp_timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  args_q       <= bus.cmd_args;
                  nargs_q      <= nargs_cl;
                  nresp_q      <= nresp_cl;
                  idx          <= '0;
                  tx_data      <= bus.cmd_opcode;
                  resp_count   <= '0;
                  resp_data    <= '0;
                  resp_timeout <= 1'b0;
               end
            end
            TX_GAP: begin
               if (idx < nargs_q) begin
                  idx     <= idx + 3'd1;
                  tx_data <= arg_byte;
               end else begin
                  tmo_cnt <= TMO_LOAD;
               end
            end
            RX: begin
               if (bus.rxReady) begin
                  for (int i = 0; i < MAXRESP; i++) begin
                     if (resp_count == 6'(i)) resp_data[8*i +: 8] <= bus.rxData;
                  end
                  resp_count <= resp_count + 6'd1;
                  tmo_cnt    <= TMO_LOAD;
               end else if (tmo_hit) begin
                  resp_timeout <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.cmd_ready    = (state == IDLE);
   assign bus.busy         = (state != IDLE);
   assign bus.txStart      = tx_start;
   assign bus.txData       = tx_data;
   assign bus.resp_valid   = (state == DONE);
   assign bus.resp_timeout = resp_timeout;
   assign bus.resp_count   = resp_count;
   assign bus.resp_data    = resp_data;
endmodule

// File: tb/tb_serial_cmd_initiator.sv
// Directed bench for serial_cmd_initiator: one task per scenario with hand-computed expectations.
module tb_serial_cmd_initiator;
   localparam int MAXRESP = 32;
   localparam int TIMEOUT = 100;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   serial_cmd_initiator_if #(.MAXRESP(MAXRESP)) bus ();

   serial_cmd_initiator #(.MAXRESP(MAXRESP), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rv_cnt = 0;
   int rv_cyc = 0;
   logic [7:0] tx_q[$];
   int tx_cyc_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.txStart === 1'b1) begin
         tx_q.push_back(bus.txData);
         tx_cyc_q.push_back(cyc);
      end
      if (bus.resp_valid === 1'b1) begin
         rv_cnt = rv_cnt + 1;
         rv_cyc = cyc;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_tx();
      tx_q.delete();
      tx_cyc_q.delete();
   endtask

   task automatic issue_cmd(input logic [7:0] op, input logic [2:0] na, input logic [31:0] a,
                            input logic [5:0] nr, output int acc);
      int b;
      b = 0;
      while (bus.cmd_ready !== 1'b1 && b < 300) begin
         step();
         b++;
      end
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL issue_ready: cmd_ready=%b required 1", bus.cmd_ready);
      end
      bus.cmd_opcode = op;
      bus.cmd_nargs  = na;
      bus.cmd_args   = a;
      bus.cmd_nresp  = nr;
      bus.cmd_valid  = 1'b1;
      @(posedge clk);
      acc = cyc;
      #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_resp(input int n0, input string nm);
      int b;
      b = 0;
      while (rv_cnt == n0 && b < 400) begin
         step();
         b++;
      end
      checks++;
      if (rv_cnt != n0 + 1) begin
         errors++;
         $display("FAIL %s_resp_valid: pulses=%0d required 1", nm, rv_cnt - n0);
      end
   endtask

   task automatic send_rx(input logic [7:0] d);
      bus.rxData  = d;
      bus.rxReady = 1'b1;
      step();
      bus.rxReady = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) step();
      checks++;
      if ({bus.busy, bus.txStart, bus.resp_valid, bus.resp_timeout} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: busy/txStart/resp_valid/resp_timeout=%b required 0000",
                  {bus.busy, bus.txStart, bus.resp_valid, bus.resp_timeout});
      end
      checks++;
      if (bus.txData !== 8'h00 || bus.resp_count !== 6'd0 || bus.resp_data !== '0) begin
         errors++;
         $display("FAIL reset_data: txData=%h resp_count=%0d resp_data=%h required 0",
                  bus.txData, bus.resp_count, bus.resp_data);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: cmd_ready=%b required 1", bus.cmd_ready);
      end
   endtask

   task automatic test_latency();
      int acc, n0;
      n0 = rv_cnt;
      clear_tx();
      issue_cmd(8'h3C, 3'd0, 32'h0, 6'd0, acc);
      step();
      step();
      checks++;
      if (bus.cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL lat_ready_done: cmd_ready=%b required 0", bus.cmd_ready);
      end
      step();
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL lat_ready_back: cmd_ready=%b required 1", bus.cmd_ready);
      end
      wait_resp(n0, "lat");
      checks++;
      if (rv_cyc != acc + 3) begin
         errors++;
         $display("FAIL lat_resp_cycle: got %0d required %0d", rv_cyc - acc, 3);
      end
      checks++;
      if (tx_q.size() != 1) begin
         errors++;
         $display("FAIL lat_tx_count: got %0d required 1", tx_q.size());
      end else if (tx_q[0] !== 8'h3C || tx_cyc_q[0] != acc + 1) begin
         errors++;
         $display("FAIL lat_tx: byte %h at +%0d required 3c at +1", tx_q[0], tx_cyc_q[0] - acc);
      end
   endtask

   task automatic test_version();
      int acc, n0;
      n0 = rv_cnt;
      clear_tx();
      issue_cmd(8'h00, 3'd0, 32'h0, 6'd1, acc);
      repeat (40) step();
      send_rx(8'h05);
      wait_resp(n0, "ver");
      checks++;
      if (tx_q.size() != 1 || tx_q[0] !== 8'h00) begin
         errors++;
         $display("FAIL ver_tx: count %0d required 1 byte 00", tx_q.size());
      end
      checks++;
      if (bus.resp_count !== 6'd1 || bus.resp_timeout !== 1'b0) begin
         errors++;
         $display("FAIL ver_status: count=%0d timeout=%b required 1,0", bus.resp_count, bus.resp_timeout);
      end
      checks++;
      if (bus.resp_data !== 256'h05) begin
         errors++;
         $display("FAIL ver_data: got %h required 05", bus.resp_data);
      end
   endtask

   task automatic test_prescale();
      int acc, n0;
      logic [7:0] exp_b[5];
      exp_b = '{8'h07, 8'h78, 8'h56, 8'h34, 8'h12};
      n0 = rv_cnt;
      clear_tx();
      issue_cmd(8'h07, 3'd4, 32'h12345678, 6'd0, acc);
      wait_resp(n0, "pre");
      checks++;
      if (tx_q.size() != 5) begin
         errors++;
         $display("FAIL pre_tx_count: got %0d required 5", tx_q.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (tx_q[i] !== exp_b[i]) begin
               errors++;
               $display("FAIL pre_tx_byte%0d: got %h required %h", i, tx_q[i], exp_b[i]);
            end
         end
         for (int i = 1; i < 5; i++) begin
            checks++;
            if (tx_cyc_q[i] - tx_cyc_q[i-1] < 2) begin
               errors++;
               $display("FAIL pre_tx_spacing%0d: got %0d required >=2", i, tx_cyc_q[i] - tx_cyc_q[i-1]);
            end
         end
         checks++;
         if (rv_cyc != tx_cyc_q[4] + 2) begin
            errors++;
            $display("FAIL pre_resp_cycle: got +%0d after last start required +2", rv_cyc - tx_cyc_q[4]);
         end
      end
      checks++;
      if (bus.resp_count !== 6'd0) begin
         errors++;
         $display("FAIL pre_count: got %0d required 0", bus.resp_count);
      end
   endtask

   task automatic test_histo();
      int acc, n0;
      logic [8*MAXRESP-1:0] exp_d;
      for (int i = 0; i < MAXRESP; i++) exp_d[8*i +: 8] = 8'(i);
      n0 = rv_cnt;
      issue_cmd(8'h0A, 3'd0, 32'h0, 6'd32, acc);
      step();
      step();
      for (int i = 0; i < 32; i++) send_rx(8'(i));
      send_rx(8'hEE);
      send_rx(8'hEF);
      wait_resp(n0, "histo");
      checks++;
      if (rv_cyc != acc + 35) begin
         errors++;
         $display("FAIL histo_resp_cycle: got +%0d required +35", rv_cyc - acc);
      end
      checks++;
      if (bus.resp_count !== 6'd32 || bus.resp_timeout !== 1'b0) begin
         errors++;
         $display("FAIL histo_status: count=%0d timeout=%b required 32,0", bus.resp_count, bus.resp_timeout);
      end
      checks++;
      if (bus.resp_data !== exp_d) begin
         errors++;
         $display("FAIL histo_data: got %h required %h", bus.resp_data, exp_d);
      end
   endtask

   task automatic test_timeout();
      int acc, n0;
      n0 = rv_cnt;
      issue_cmd(8'h08, 3'd0, 32'h0, 6'd1, acc);
      wait_resp(n0, "tmo");
      checks++;
      if (rv_cyc != acc + 103) begin
         errors++;
         $display("FAIL tmo_cycle: got +%0d from RX entry required +100", rv_cyc - acc - 3);
      end
      checks++;
      if (bus.resp_timeout !== 1'b1 || bus.resp_count !== 6'd0) begin
         errors++;
         $display("FAIL tmo_status: timeout=%b count=%0d required 1,0", bus.resp_timeout, bus.resp_count);
      end

      n0 = rv_cnt;
      issue_cmd(8'h08, 3'd0, 32'h0, 6'd1, acc);
      repeat (101) step();
      send_rx(8'hA5);
      wait_resp(n0, "tmo_edge");
      checks++;
      if (rv_cyc != acc + 103 || bus.resp_timeout !== 1'b0 || bus.resp_count !== 6'd1) begin
         errors++;
         $display("FAIL tmo_edge: cycle +%0d timeout=%b count=%0d required +103,0,1",
                  rv_cyc - acc, bus.resp_timeout, bus.resp_count);
      end
      checks++;
      if (bus.resp_data[7:0] !== 8'hA5) begin
         errors++;
         $display("FAIL tmo_edge_data: got %h required a5", bus.resp_data[7:0]);
      end

      n0 = rv_cnt;
      issue_cmd(8'h08, 3'd0, 32'h0, 6'd2, acc);
      repeat (101) step();
      send_rx(8'h5A);
      wait_resp(n0, "tmo_restart");
      checks++;
      if (rv_cyc != acc + 203 || bus.resp_timeout !== 1'b1 || bus.resp_count !== 6'd1) begin
         errors++;
         $display("FAIL tmo_restart: cycle +%0d timeout=%b count=%0d required +203,1,1",
                  rv_cyc - acc, bus.resp_timeout, bus.resp_count);
      end
   endtask

   task automatic test_backpressure();
      int acc, n0;
      logic [7:0] exp_b[5];
      exp_b = '{8'h21, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      n0 = rv_cnt;
      clear_tx();
      issue_cmd(8'h21, 3'd7, 32'hDDCCBBAA, 6'd0, acc);
      step();
      bus.txBusy = 1'b1;
      repeat (50) step();
      bus.txBusy = 1'b0;
      wait_resp(n0, "bp");
      checks++;
      if (tx_q.size() != 5) begin
         errors++;
         $display("FAIL bp_tx_count: got %0d required 5", tx_q.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (tx_q[i] !== exp_b[i]) begin
               errors++;
               $display("FAIL bp_tx_byte%0d: got %h required %h", i, tx_q[i], exp_b[i]);
            end
         end
         checks++;
         if (tx_cyc_q[1] != acc + 52) begin
            errors++;
            $display("FAIL bp_release: second start at +%0d required +52", tx_cyc_q[1] - acc);
         end
      end
      checks++;
      if (rv_cyc != acc + 60) begin
         errors++;
         $display("FAIL bp_resp_cycle: got +%0d required +60", rv_cyc - acc);
      end
   endtask

   task automatic test_reset_mid_rx();
      int acc, acc2, n0, rel;
      n0 = rv_cnt;
      issue_cmd(8'h30, 3'd0, 32'h0, 6'd8, acc);
      step();
      step();
      send_rx(8'h11);
      send_rx(8'h22);
      send_rx(8'h33);
      reset = 1'b1;
      step();
      checks++;
      if (bus.resp_count !== 6'd0 || bus.resp_data !== '0 || bus.txData !== 8'h00) begin
         errors++;
         $display("FAIL rst_mid_data: count=%0d data=%h txData=%h required 0",
                  bus.resp_count, bus.resp_data, bus.txData);
      end
      checks++;
      if ({bus.busy, bus.txStart, bus.resp_valid, bus.resp_timeout} !== 4'b0000 || rv_cnt != n0) begin
         errors++;
         $display("FAIL rst_mid_flags: busy/txStart/resp_valid/resp_timeout=%b pulses=%0d required 0000,0",
                  {bus.busy, bus.txStart, bus.resp_valid, bus.resp_timeout}, rv_cnt - n0);
      end
      reset = 1'b0;
      rel = cyc;
      clear_tx();
      issue_cmd(8'h31, 3'd1, 32'h77, 6'd2, acc2);
      checks++;
      if (acc2 != rel) begin
         errors++;
         $display("FAIL rst_mid_accept: accepted %0d cycles after release required 0", acc2 - rel);
      end
      repeat (4) step();
      send_rx(8'h44);
      send_rx(8'h55);
      wait_resp(n0, "rst_mid");
      checks++;
      if (tx_q.size() != 2 || tx_q[0] !== 8'h31 || tx_q[1] !== 8'h77) begin
         errors++;
         $display("FAIL rst_mid_tx: count %0d required bytes 31,77", tx_q.size());
      end
      checks++;
      if (bus.resp_count !== 6'd2 || bus.resp_data !== 256'h5544 || bus.resp_timeout !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_resp: count=%0d data=%h timeout=%b required 2,5544,0",
                  bus.resp_count, bus.resp_data, bus.resp_timeout);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1);
   end

   initial begin
      bus.cmd_valid  = 1'b0;
      bus.cmd_opcode = 8'h00;
      bus.cmd_nargs  = 3'd0;
      bus.cmd_args   = 32'h0;
      bus.cmd_nresp  = 6'd0;
      bus.txBusy     = 1'b0;
      bus.rxReady    = 1'b0;
      bus.rxData     = 8'h00;
      test_reset();
      test_latency();
      test_version();
      test_prescale();
      test_histo();
      test_timeout();
      test_backpressure();
      test_reset_mid_rx();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/serial_cmd_initiator.md
Name: serial_cmd_initiator

Overview:
Host-side command sequencer for the board's byte-serial control protocol. It is the initiator end: it issues a command opcode plus 0-4 little-endian argument bytes to a UART transmitter, then collects up to 32 response bytes from a UART receiver, with an inactivity timeout. It sits between a local controller (master board logic or test sequencer) and a UART pair that link to a downstream board's command processor.

Parameters:
MAXRESP, 32, maximum response bytes captured; fixed width of resp_data = 8*MAXRESP.
TIMEOUT, 1000000, clk cycles of rx inactivity tolerated in RX before giving up (>=2).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  high when a command can be accepted
cmd_opcode  in  8  command byte sent first
cmd_nargs  in  3  argument byte count; values >4 clamped to 4
cmd_args  in  32  args; byte k = cmd_args[8k+7:8k], sent k=0 first
cmd_nresp  in  6  expected response bytes; values >MAXRESP clamped to MAXRESP
txBusy  in  1  UART tx busy
txStart  out  1  one-cycle start pulse to UART tx
txData  out  8  byte to transmit, valid with txStart
rxReady  in  1  one-cycle strobe, rxData valid
rxData  in  8  received byte
resp_valid  out  1  one-cycle pulse: command finished
resp_timeout  out  1  set with resp_valid if timeout ended the command
resp_count  out  6  response bytes captured
resp_data  out  8*MAXRESP  byte i = [8i+7:8i], in arrival order
busy  out  1  high whenever not IDLE

Behaviour:
- Reset (sync, active-high, overrides everything incl. mid-transfer): state IDLE; txStart=0, txData=0, resp_valid=0, resp_timeout=0, resp_count=0, resp_data=0, busy=0. cmd_ready=1 on first cycle after reset deasserts.
- States: IDLE, TX_WAIT, TX_GAP, RX, DONE.
- IDLE: cmd_ready=1. On cmd_valid: latch opcode/args/clamped nargs/nresp; byte index=0; clear resp_count, resp_data, resp_timeout; go TX_WAIT. cmd_ready=0 outside IDLE.
- TX_WAIT: if !txBusy: txData=current byte (index 0 = opcode, index k = arg byte k-1), txStart=1 for exactly this cycle, go TX_GAP; else hold, txStart=0, txData unchanged.
- TX_GAP: txStart=0 (one mandatory idle cycle so UART can raise txBusy). If index < nargs: index+1, go TX_WAIT. Else if nresp==0 go DONE, else clear timeout counter, go RX. Min 2 cycles per byte.
- RX: on rxReady: resp_data byte[resp_count]=rxData, resp_count+1, timeout counter cleared; if new count==nresp go DONE. Without rxReady counter increments; at TIMEOUT-1 with no rxReady go DONE with resp_timeout=1. rxReady in same cycle as expiry: byte captured, counter cleared, no timeout.
- DONE: resp_valid=1 one cycle; go IDLE. resp_count/resp_data/resp_timeout hold until next accept.
- rxReady outside RX (IDLE, TX_WAIT, TX_GAP, DONE): byte discarded, no state change.
- Latency (txBusy low, nargs=0, nresp=0): accept cycle 0, txStart cycle 1, TX_GAP cycle 2, resp_valid cycle 3, cmd_ready cycle 4.
- resp_count never exceeds nresp; counters do not wrap.

Test Plan:
- Version query: opcode 0x00, nargs 0, nresp 1; model replies 0x05 after 40 cycles -> tx bytes [00], resp_valid pulse, resp_count=1, resp_data[7:0]=0x05, resp_timeout=0.
- Prescale set: opcode 0x07, nargs 4, args 0x12345678, nresp 0 -> txData sequence 07,78,56,34,12, each txStart one cycle wide, >=2 cycles apart; resp_valid 1 cycle after last gap; resp_count=0.
- Histo read: opcode 0x0A, nresp 32; model sends bytes 0x00..0x1F -> resp_count=32, byte i = i, no timeout; 33rd stray byte ignored.
- Timeout (TIMEOUT=100): opcode 0x08, nresp 1, no reply -> resp_valid with resp_timeout=1, resp_count=0, exactly 100 cycles after RX entry; repeat with rxReady at expiry cycle -> captured, no timeout.
- Backpressure: txBusy high 50 cycles after first byte -> txStart stays 0, next byte sent first cycle txBusy low, no bytes lost/duplicated; nargs=7 sends only 4 args.
- Reset mid-RX after 3 of 8 bytes -> all outputs to reset values; new command accepted next cycle after release and completes normally.
